// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Merges two register-file writeback streams onto the single write port of the
// register file. Requester A is the ALU writeback path, requester B is the
// load writeback path. Each requester owns a one-entry hold slot. Every cycle
// one valid slot is granted, and its entry moves into a registered write
// stage that drives the register file port directly.
//
// Configuration macros:
//   RF_ARB_RR_EN  defined   -> round-robin between the two slots when both are
//                              valid. The requester not granted last wins.
//                 undefined -> fixed priority. A always wins when both are
//                              valid, and no pointer register is built.
//   DATA_WIDTH    optional global default for the DATA_WIDTH parameter (32).
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst           asynchronous, active-high reset
//   a_valid       A has a write pending
//   a_ready       A transfer is accepted on the next rising edge
//   a_rd          A destination register index
//   a_wd          A write data
//   b_valid       B has a write pending
//   b_ready       B transfer is accepted on the next rising edge
//   b_rd          B destination register index
//   b_wd          B write data
//   rf_wr         registered write enable to the register file
//   rf_rd         registered destination index to the register file
//   rf_wd         registered write data to the register file
//   pend          bit i set while an accepted, unretired write targets reg i
//   conflict_cnt  saturating count of edges on which both slots were valid
// -----------------------------------------------------------------------------

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module regfile_write_arbiter #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [4:0]            a_rd,
  input  logic [DATA_WIDTH-1:0] a_wd,

  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [4:0]            b_rd,
  input  logic [DATA_WIDTH-1:0] b_wd,

  output logic                  rf_wr,
  output logic [4:0]            rf_rd,
  output logic [DATA_WIDTH-1:0] rf_wd,

  output logic [31:0]           pend,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);

  // Hold slot for requester A.
  logic                  hold_a_valid;
  logic [4:0]            hold_a_rd;
  logic [DATA_WIDTH-1:0] hold_a_wd;

  // Hold slot for requester B.
  logic                  hold_b_valid;
  logic [4:0]            hold_b_rd;
  logic [DATA_WIDTH-1:0] hold_b_wd;

  // Combinational grant. At most one of these is high in any cycle.
  logic grant_a;
  logic grant_b;

  // Transfer strobes and the subset that actually fills a slot. Writes to
  // x0 are handshaken normally but dropped, because x0 is hardwired to zero.
  logic a_xfer;
  logic b_xfer;
  logic a_load;
  logic b_load;

  // A slot can take a new entry when it is empty, or when it is being issued
  // on this same edge. Ready does not look at valid, so the requester never
  // sees a combinational loop through this block.
  assign a_ready = !hold_a_valid || grant_a;
  assign b_ready = !hold_b_valid || grant_b;

  assign a_xfer = a_valid && a_ready;
  assign b_xfer = b_valid && b_ready;
  assign a_load = a_xfer && (a_rd != 5'd0);
  assign b_load = b_xfer && (b_rd != 5'd0);

`ifdef RF_ARB_RR_EN
  // Round-robin pointer. Low means A has priority on the next collision.
  // After any grant, priority moves to the requester that was not granted.
  logic rr_ptr_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_b <= 1'b0;
    end else if (grant_a) begin
      rr_ptr_b <= 1'b1;
    end else if (grant_b) begin
      rr_ptr_b <= 1'b0;
    end
  end

  // Grant when this slot is the only one valid, or when both are valid and
  // the pointer favours it.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (hold_a_valid && (!hold_b_valid || !rr_ptr_b)) begin
      grant_a = 1'b1;
    end else if (hold_b_valid) begin
      grant_b = 1'b1;
    end
  end
`else
  // Fixed priority. The ALU path always wins, so a stalled load writeback
  // waits until the ALU stream pauses.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (hold_a_valid) begin
      grant_a = 1'b1;
    end else if (hold_b_valid) begin
      grant_b = 1'b1;
    end
  end
`endif

  // Slot A. An issue clears the slot. A load on the same edge wins, so a
  // drain and refill together leaves the new entry stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_a_valid <= 1'b0;
      hold_a_rd    <= 5'd0;
      hold_a_wd    <= '0;
    end else begin
      if (grant_a) begin
        hold_a_valid <= 1'b0;
      end
      if (a_load) begin
        hold_a_valid <= 1'b1;
        hold_a_rd    <= a_rd;
        hold_a_wd    <= a_wd;
      end
    end
  end

  // Slot B. Same drain and refill behaviour as slot A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_b_valid <= 1'b0;
      hold_b_rd    <= 5'd0;
      hold_b_wd    <= '0;
    end else begin
      if (grant_b) begin
        hold_b_valid <= 1'b0;
      end
      if (b_load) begin
        hold_b_valid <= 1'b1;
        hold_b_rd    <= b_rd;
        hold_b_wd    <= b_wd;
      end
    end
  end

  // Registered write stage. Index and data keep their last values when idle,
  // so only rf_wr toggles between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wr <= 1'b0;
      rf_rd <= 5'd0;
      rf_wd <= '0;
    end else if (grant_a) begin
      rf_wr <= 1'b1;
      rf_rd <= hold_a_rd;
      rf_wd <= hold_a_wd;
    end else if (grant_b) begin
      rf_wr <= 1'b1;
      rf_rd <= hold_b_rd;
      rf_wd <= hold_b_wd;
    end else begin
      rf_wr <= 1'b0;
    end
  end

  // Counts edges on which both slots are valid. It stops at all-ones so a
  // long contention run cannot wrap back to a small value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (hold_a_valid && hold_b_valid && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
    end
  end

  // Scoreboard for hazard logic. A register stays pending from acceptance
  // until its write leaves the write stage. Bit 0 is never set because
  // x0 writes are dropped.
  always_comb begin
    pend = '0;
    for (int i = 1; i < 32; i++) begin
      pend[i] = (hold_a_valid && (hold_a_rd == 5'(i))) ||
                (hold_b_valid && (hold_b_rd == 5'(i))) ||
                (rf_wr        && (rf_rd     == 5'(i)));
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Directed bench for regfile_write_arbiter. The bench pushes each write it
// expects onto a queue when it drives the stimulus. A negedge monitor pops the
// queue whenever rf_wr is high and compares index and data. The directed steps
// check the reset state, latency, pend, ready, conflict counting and
// saturation. The DUT uses a 4-bit conflict counter so that saturation is
// reached quickly.
// -----------------------------------------------------------------------------

module tb_regfile_write_arbiter;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_valid;
  logic          a_ready;
  logic [4:0]    a_rd;
  logic [DW-1:0] a_wd;
  logic          b_valid;
  logic          b_ready;
  logic [4:0]    b_rd;
  logic [DW-1:0] b_wd;
  logic          rf_wr;
  logic [4:0]    rf_rd;
  logic [DW-1:0] rf_wd;
  logic [31:0]   pend;
  logic [CW-1:0] conflict_cnt;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wd;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int  total = 0;
  int  bad   = 0;

  regfile_write_arbiter #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_rd         (a_rd),
    .a_wd         (a_wd),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_rd         (b_rd),
    .b_wd         (b_wd),
    .rf_wr        (rf_wr),
    .rf_rd        (rf_rd),
    .rf_wd        (rf_wd),
    .pend         (pend),
    .conflict_cnt (conflict_cnt)
  );

  // 10-time-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                               input logic bv, input logic [4:0] brd, input logic [31:0] bwd);
    a_valid = av;
    a_rd    = ard;
    a_wd    = awd;
    b_valid = bv;
    b_rd    = brd;
    b_wd    = bwd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expectWrite(input logic [4:0] rd, input logic [31:0] wd);
    wr_t e;
    e.rd = rd;
    e.wd = wd;
    sb.push_back(e);
  endtask

  task automatic idle;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic doReset;
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [4:0] a_rd_of(input int k);
    return 5'(1 + (k % 15));
  endfunction

  function automatic logic [4:0] b_rd_of(input int k);
    return 5'(16 + (k % 15));
  endfunction

  function automatic logic [31:0] a_wd_of(input int n, input int k);
    return 32'hA000_0000 | (32'(n) << 16) | 32'(k);
  endfunction

  function automatic logic [31:0] b_wd_of(input int n, input int k);
    return 32'hB000_0000 | (32'(n) << 16) | 32'(k);
  endfunction

  // Scoreboard monitor: every write leaving the DUT must match the oldest
  // expected entry.
  always @(negedge clk) begin
    if (!rst && rf_wr !== 1'b0) begin
      if (sb.size() == 0) begin
        checkOutput("rf_wr_unexpected", 32'(rf_wr), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("sb_rd", 32'(rf_rd), 32'(mon_e.rd));
        checkOutput("sb_wd", rf_wd, mon_e.wd);
      end
    end
  end

  // Both requesters each stream n writes from an idle, freshly reset state.
  // A requester holds its payload until it is accepted.
  task automatic runStream(input int n, input int cnt_start);
    int ai = 0;
    int bi = 0;
    int c  = 0;
    int contended;
    int expc;
    logic ar;
    logic br;
`ifdef RF_ARB_RR_EN
    for (int k = 0; k < n; k++) begin
      expectWrite(a_rd_of(k), a_wd_of(n, k));
      expectWrite(b_rd_of(k), b_wd_of(n, k));
    end
    contended = 2 * n - 1;
`else
    for (int k = 0; k < n; k++) expectWrite(a_rd_of(k), a_wd_of(n, k));
    for (int k = 0; k < n; k++) expectWrite(b_rd_of(k), b_wd_of(n, k));
    contended = n;
`endif
    expc = cnt_start + contended;
    if (expc > 15) expc = 15;
    while (c < 4 * n + 20 && (ai < n || bi < n || sb.size() != 0)) begin
      applyStimulus(ai < n, a_rd_of(ai), a_wd_of(n, ai), bi < n, b_rd_of(bi), b_wd_of(n, bi));
      ar = a_ready;
      br = b_ready;
      if (c == 1)
        checkOutput("stream_pend_c1", pend, (32'd1 << a_rd_of(0)) | (32'd1 << b_rd_of(0)));
      if (c == 2)
        checkOutput("stream_pend_c2", pend,
                    (32'd1 << a_rd_of(0)) | (32'd1 << a_rd_of(1)) | (32'd1 << b_rd_of(0)));
`ifdef RF_ARB_RR_EN
      if (c >= 1 && c <= 2 * n - 1) begin
        checkOutput("rr_a_ready", 32'(ar), 32'((c % 2) == 1));
        checkOutput("rr_b_ready", 32'(br), 32'((c % 2) == 0));
      end
`else
      if (c >= 1 && c <= n) begin
        checkOutput("fp_a_ready", 32'(ar), 32'd1);
        checkOutput("fp_b_stall", 32'(br), 32'd0);
      end
`endif
      tick();
      if (a_valid && ar) ai++;
      if (b_valid && br) bi++;
      c++;
    end
    idle();
    checkOutput("stream_accepted", 32'(ai + bi), 32'(2 * n));
    checkOutput("stream_drained", 32'(sb.size()), 32'd0);
    checkOutput("stream_conflict_cnt", 32'(conflict_cnt), 32'(expc));
  endtask

  initial begin
    // Reset held while requesters present writes. Nothing may be taken.
    rst = 1'b1;
    applyStimulus(1'b1, 5'd5, 32'h5555_AAAA, 1'b1, 5'd7, 32'h7777_7777);
    tick();
    tick();
    checkOutput("rst_rf_wr", 32'(rf_wr), 32'd0);
    checkOutput("rst_rf_rd", 32'(rf_rd), 32'd0);
    checkOutput("rst_rf_wd", rf_wd, 32'd0);
    checkOutput("rst_pend", pend, 32'd0);
    checkOutput("rst_cnt", 32'(conflict_cnt), 32'd0);
    checkOutput("rst_a_ready", 32'(a_ready), 32'd1);
    checkOutput("rst_b_ready", 32'(b_ready), 32'd1);
    idle();
    rst = 1'b0;
    tick();
    checkOutput("post_rst_rf_wr", 32'(rf_wr), 32'd0);
    checkOutput("post_rst_pend", pend, 32'd0);

    // Collision on x3. A issues first, then B, and B's data is final.
    applyStimulus(1'b1, 5'd3, 32'h5555_5555, 1'b1, 5'd3, 32'h1234_5678);
    expectWrite(5'd3, 32'h5555_5555);
    expectWrite(5'd3, 32'h1234_5678);
    checkOutput("col_a_ready_empty", 32'(a_ready), 32'd1);
    checkOutput("col_b_ready_empty", 32'(b_ready), 32'd1);
    tick();
    idle();
    checkOutput("col_pend_held", pend, 32'h0000_0008);
    checkOutput("col_cnt_before", 32'(conflict_cnt), 32'd0);
    checkOutput("col_rf_wr_lat", 32'(rf_wr), 32'd0);
    checkOutput("col_b_ready_blocked", 32'(b_ready), 32'd0);
    tick();
    checkOutput("col_first_wr", 32'(rf_wr), 32'd1);
    checkOutput("col_first_wd", rf_wd, 32'h5555_5555);
    checkOutput("col_cnt", 32'(conflict_cnt), 32'd1);
    checkOutput("col_b_ready_drain", 32'(b_ready), 32'd1);
    tick();
    checkOutput("col_second_wd", rf_wd, 32'h1234_5678);
    checkOutput("col_cnt_hold", 32'(conflict_cnt), 32'd1);
    tick();
    checkOutput("col_idle_rf_wr", 32'(rf_wr), 32'd0);
    checkOutput("col_idle_pend", pend, 32'd0);

    // Fairness / priority and sustained throughput.
    doReset();
    runStream(6, 0);

    // Write to x0 is accepted and dropped.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    checkOutput("x0_b_ready", 32'(b_ready), 32'd1);
    tick();
    idle();
    checkOutput("x0_pend", pend, 32'd0);
    checkOutput("x0_rf_wr", 32'(rf_wr), 32'd0);
    tick();
    checkOutput("x0_rf_wr_late", 32'(rf_wr), 32'd0);
    checkOutput("x0_pend_late", pend, 32'd0);

    // Single write: a one-cycle pulse after the latency, and two cycles of pend.
    applyStimulus(1'b1, 5'd6, 32'hAAAA_AAAA, 1'b0, 5'd0, 32'd0);
    expectWrite(5'd6, 32'hAAAA_AAAA);
    checkOutput("sw_a_ready", 32'(a_ready), 32'd1);
    tick();
    idle();
    checkOutput("sw_pend_slot", pend, 32'h0000_0040);
    checkOutput("sw_rf_wr_early", 32'(rf_wr), 32'd0);
    tick();
    checkOutput("sw_rf_wr", 32'(rf_wr), 32'd1);
    checkOutput("sw_rf_rd", 32'(rf_rd), 32'd6);
    checkOutput("sw_rf_wd", rf_wd, 32'hAAAA_AAAA);
    checkOutput("sw_pend_issue", pend, 32'h0000_0040);
    tick();
    checkOutput("sw_rf_wr_end", 32'(rf_wr), 32'd0);
    checkOutput("sw_pend_end", pend, 32'd0);

    // Reset while a write to x9 is held. The write must vanish.
    applyStimulus(1'b1, 5'd9, 32'h9999_9999, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("mf_pend_before", pend, 32'h0000_0200);
    rst = 1'b1;
    #1;
    checkOutput("mf_pend", pend, 32'd0);
    checkOutput("mf_rf_wr", 32'(rf_wr), 32'd0);
    checkOutput("mf_rf_rd", 32'(rf_rd), 32'd0);
    checkOutput("mf_cnt", 32'(conflict_cnt), 32'd0);
    idle();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("mf_no_wr", 32'(rf_wr), 32'd0);
    end

    // Long contention run saturates the 4-bit counter.
    runStream(20, 0);
    tick();
    tick();
    checkOutput("sat_hold", 32'(conflict_cnt), 32'h0000_000F);

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so that a stuck run still ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default `DATA_WIDTH (32), width of write data on all ports.
REQ-002 Parameter CNT_WIDTH, default 16, width of the conflict counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-006 a_ready  output  1  arbiter accepts A this cycle.
REQ-007 a_rd  input  5  A destination register index.
REQ-008 a_wd  input  DATA_WIDTH  A write data.
REQ-009 b_valid, b_ready, b_rd, b_wd: same as REQ-005..008 for requester B (load writeback).
REQ-010 rf_wr  output  1  registered write enable to register file port wr.
REQ-011 rf_rd  output  5  registered destination index to register file port rd.
REQ-012 rf_wd  output  DATA_WIDTH  registered write data to register file port wd.
REQ-013 pend  output  32  bit i high while any accepted, unretired write targets register i.
REQ-014 conflict_cnt  output  CNT_WIDTH  count of cycles in which both hold slots competed.

Function
REQ-015 Each requester owns one hold slot (valid, rd, wd); transfer occurs on an edge where x_valid && x_ready.
REQ-016 x_ready = !hold_x_valid || grant_x (slot empty or being drained this cycle); combinational, no dependency on x_valid.
REQ-017 A transfer with x_rd == 0 is accepted but not loaded into the slot; it never produces rf_wr and never sets pend.
REQ-018 Grant is combinational among valid slots; exactly one grant per cycle when at least one slot is valid, none otherwise.
REQ-019 On an edge with a grant: rf_wr<=1, rf_rd/rf_wd <= granted slot; granted slot clears unless refilled on the same edge.
REQ-020 On an edge with no grant: rf_wr<=0; rf_rd/rf_wd hold previous values.
REQ-021 Latency: accepted at edge N, uncontended -> rf_wr high during cycle after edge N+1 -> register file written at edge N+2.
REQ-022 Simultaneous drain and refill of the same slot on one edge is legal; new entry is stored, old entry is issued.
REQ-023 Both slots same rd: entries issue in grant order; last issued value is the final register value.
REQ-024 pend[i] = (hold_a_valid && hold_a_rd==i) | (hold_b_valid && hold_b_rd==i) | (rf_wr && rf_rd==i); pend[0] always 0.
REQ-025 conflict_cnt increments on each edge where both slots are valid; saturates at all-ones, no wrap.
REQ-026 Back-to-back throughput: one register-file write per cycle sustained with either requester continuously valid.

Reset
REQ-027 rst high forces immediately: both slots invalid, rf_wr=0, rf_rd=0, rf_wd=0, conflict_cnt=0, round-robin pointer=A.
REQ-028 While rst high: a_ready=b_ready=1 permitted but no transfer takes effect; pend=0.
REQ-029 Reset mid-operation discards held and in-flight writes; no rf_wr pulse after rst deasserts until a new transfer.

Configuration
REQ-030 Macro RF_ARB_RR_EN defined: round-robin; when both slots valid, grant the requester not granted last; pointer updates on every grant.
REQ-031 Macro RF_ARB_RR_EN undefined: fixed priority, A always wins when both valid; no pointer register exists.

Verification
REQ-032 Single write: A writes rd=6, wd=AAAAAAAA for one cycle -> rf_wr pulse one cycle, rf_rd=6, rf_wd=AAAAAAAA; pend[6] high for 2 cycles.
REQ-033 Collision: A rd=3/55555555 and B rd=3/12345678 same edge -> RR: A then B; fixed: A then B; final reg3=12345678; conflict_cnt=1.
REQ-034 Fairness (RF_ARB_RR_EN): both valid continuously 8 cycles -> grants alternate A,B,A,B...; without macro B ready stays 0 after first transfer until A drops.
REQ-035 x0 drop: B rd=0, wd=FFFFFFFF -> b_ready=1, no rf_wr, pend all zero.
REQ-036 Reset mid-flight: accept A rd=9, assert rst before issue -> rf_wr never pulses, pend[9]=0, conflict_cnt=0.
REQ-037 Saturation: CNT_WIDTH=4, 20 contended cycles -> conflict_cnt=F and holds.
